pipeline_hazard_ctrl: RTL

Central hazard and sequencing controller for the 5-stage pipeline (IF, ID, EX, DM, WB).
- Drives the PC enable plus the en / clr controls of the IF/ID, ID/EX, EX/DM and DM/WB pipeline registers.
- Generates the EX-stage operand forwarding selects.
- Sequences the syscall halt drain.
- Keeps saturating stall and flush performance counters.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 20 ++
 rtl/pipeline_hazard_ctrl_fwd_unit.sv | 28 ++
 rtl/pipeline_hazard_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller.
//   FWD_*   : EX operand source selects (register file, EX/DM result, WB data)
//   ST_*    : controller sequencing states
package pipeline_hazard_ctrl_pkg;

  localparam int FWD_BIT      = 2;
  localparam int HC_STATE_BIT = 2;

  typedef logic [FWD_BIT-1:0]      fwd_sel_t;
  typedef logic [HC_STATE_BIT-1:0] hc_state_t;

  localparam fwd_sel_t FWD_RF   = 2'd0;
  localparam fwd_sel_t FWD_EXDM = 2'd1;
  localparam fwd_sel_t FWD_WB   = 2'd2;

  localparam logic [HC_STATE_BIT-1:0] ST_RUN    = 2'd0;
  localparam logic [HC_STATE_BIT-1:0] ST_DRAIN  = 2'd1;
  localparam logic [HC_STATE_BIT-1:0] ST_HALTED = 2'd2;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// Operand forwarding select for one EX-stage source register.
// Ports:
//   src              : EX-stage source register index
//   dm_rd / dm_w_en  : DM-stage destination and write flag
//   wb_rd / wb_w_en  : WB-stage destination and write flag
//   sel              : FWD_EXDM, FWD_WB or FWD_RF
// The younger (DM) producer wins; r0 is hard-wired zero and never forwards.
module pipeline_hazard_ctrl_fwd_unit
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] dm_rd,
  input  logic       dm_w_en,
  input  logic [4:0] wb_rd,
  input  logic       wb_w_en,
  output fwd_sel_t   sel
);

  always_comb begin
    sel = FWD_RF;
    if (dm_w_en && (dm_rd != 5'd0) && (dm_rd == src)) begin
      sel = FWD_EXDM;
    end else if (wb_w_en && (wb_rd != 5'd0) && (wb_rd == src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the IF/ID/EX/DM/WB pipeline.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   id_* / ex_* / dm_* / wb_* : per-stage register indices and hazard flags
//   resume                : pulse that leaves HALTED
//   pc_en, *_en           : PC and pipeline register enables (0 = hold)
//   *_clr                 : pipeline register clears, active-low (0 = bubble)
//   fwd_a, fwd_b          : EX operand forwarding selects
//   halted                : controller is in HALTED
//   stall_cnt, flush_cnt  : saturating performance counters
//
// state   | meaning
// --------+---------------------------------------------------------
// RUN     | normal issue; hazards resolved by priority
// DRAIN   | halt seen in EX; front end frozen, back end empties
// HALTED  | halt retired; everything frozen until resume
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_jump,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_w_en,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_halt,
  input  logic [4:0]       dm_rd,
  input  logic             dm_w_en,
  input  logic             dm_access,
  input  logic             dm_ready,
  input  logic [4:0]       wb_rd,
  input  logic             wb_w_en,
  input  logic             wb_halt,
  input  logic             resume,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exdm_en,
  output logic             dmwb_en,
  output logic             ifid_clr,
  output logic             idex_clr,
  output logic             exdm_clr,
  output logic             dmwb_clr,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hc_state_t state_q, state_d;
  logic      load_use, mem_wait;
  logic      stall_inc, flush_inc;

  pipeline_hazard_ctrl_fwd_unit u_fwd_a (
    .src(ex_rs), .dm_rd(dm_rd), .dm_w_en(dm_w_en),
    .wb_rd(wb_rd), .wb_w_en(wb_w_en), .sel(fwd_a)
  );

  pipeline_hazard_ctrl_fwd_unit u_fwd_b (
    .src(ex_rt), .dm_rd(dm_rd), .dm_w_en(dm_w_en),
    .wb_rd(wb_rd), .wb_w_en(wb_w_en), .sel(fwd_b)
  );

  assign load_use = ex_mem_read && ex_w_en && (ex_rd != 5'd0) &&
                    ((id_use_rs && (ex_rd == id_rs)) || (id_use_rt && (ex_rd == id_rt)));
  assign mem_wait = dm_access && !dm_ready;

  always_comb begin
    state_d   = state_q;
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    idex_en   = 1'b1;
    exdm_en   = 1'b1;
    dmwb_en   = 1'b1;
    ifid_clr  = 1'b1;
    idex_clr  = 1'b1;
    exdm_clr  = 1'b1;
    dmwb_clr  = 1'b1;
    halted    = 1'b0;
    flush_inc = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_wait) begin
          // A taken branch waiting here stays in EX and flushes once memory is ready.
          {pc_en, ifid_en, idex_en, exdm_en, dmwb_en} = 5'b0;
        end else if (ex_branch_taken) begin
          ifid_clr  = 1'b0;
          idex_clr  = 1'b0;
          flush_inc = 1'b1;
        end else if (ex_halt) begin
          pc_en     = 1'b0;
          ifid_clr  = 1'b0;
          idex_clr  = 1'b0;
          flush_inc = 1'b1;
          state_d   = ST_DRAIN;
        end else if (load_use) begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_clr = 1'b0;
        end else if (id_jump) begin
          ifid_clr  = 1'b0;
          flush_inc = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (mem_wait) begin
          {pc_en, ifid_en, idex_en, exdm_en, dmwb_en} = 5'b0;
        end else begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_clr = 1'b0;
        end
        if (wb_halt) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        {pc_en, ifid_en, idex_en, exdm_en, dmwb_en} = 5'b0;
        halted = 1'b1;
        if (resume) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign stall_inc = (state_q == ST_RUN) && !pc_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
